bfu_pipe: RTL and testbench

- Pipelined, parametrised radix-2 DIT butterfly for the FFT datapath. Successor to the combinational add/sub butterfly.
- Adds the following:
  - complex twiddle multiply on the B leg,
  - convergent-free round-half-up rounding,
  - optional per-sample divide-by-2 scaling,
  - output saturation with per-sample and sticky overflow flags,
  - a valid-tagged 3-stage pipeline with a throughput of one butterfly per clock.
- Sits between the FFT stage memory read port and the write-back path; one instance per FFT stage engine.

---
 rtl/bfu_pipe.sv | 192 +++++++++++++++++++
 tb/tb_bfu_pipe.sv | 201 ++++++++++++++++++++
 2 files changed

// File: rtl/bfu_pipe.sv
// Pipelined radix-2 DIT butterfly: Ya = Xa + Xb*W, Yb = Xa - Xb*W.
// Three register ranks (products, rounded twiddle product, saturated outputs), one butterfly per clock.
module bfu_pipe #(
    parameter int unsigned DW = 16,
    parameter int unsigned TW = 16
) (
    input  logic          clk_i,
    input  logic          rst_i,
    input  logic          in_valid_i,
    input  logic          scale_en_i,
    input  logic [DW-1:0] xa_r_i,
    input  logic [DW-1:0] xa_i_i,
    input  logic [DW-1:0] xb_r_i,
    input  logic [DW-1:0] xb_i_i,
    input  logic [TW-1:0] w_r_i,
    input  logic [TW-1:0] w_i_i,
    input  logic          ovf_clr_i,
    output logic          out_valid_o,
    output logic [DW-1:0] ya_r_o,
    output logic [DW-1:0] ya_i_o,
    output logic [DW-1:0] yb_r_o,
    output logic [DW-1:0] yb_i_o,
    output logic          sat_o,
    output logic          ovf_sticky_o
);

    localparam int unsigned PW = DW + TW;
    localparam int unsigned SW = PW + 1;
    localparam int unsigned RW = DW + 2;
    localparam int unsigned AW = DW + 3;

    localparam logic signed [SW-1:0] RndK = SW'(1) << (TW - 2);
    localparam logic signed [AW-1:0] One  = AW'(1);
    localparam logic signed [AW-1:0] MaxV = AW'((1 << (DW - 1)) - 1);
    localparam logic signed [AW-1:0] MinV = ~MaxV;

    // Stage 1 registers
    logic                 v1_q, sc1_q;
    logic [DW-1:0]        xar1_q, xai1_q;
    logic signed [PW-1:0] m_rr_q, m_ii_q, m_ri_q, m_ir_q;
    logic signed [PW-1:0] m_rr_d, m_ii_d, m_ri_d, m_ir_d;

    // Stage 2 registers
    logic                 v2_q, sc2_q;
    logic [DW-1:0]        xar2_q, xai2_q;
    logic signed [RW-1:0] pr2_q, pi2_q;
    logic signed [RW-1:0] pr2_d, pi2_d;

    // Output registers
    logic                 out_valid_q, sat_q, sat_d, sticky_q;
    logic [DW-1:0]        ya_r_q, ya_i_q, yb_r_q, yb_i_q;
    logic [DW-1:0]        ya_r_d, ya_i_d, yb_r_d, yb_i_d;

    logic signed [PW-1:0] xbr_x, xbi_x, wr_x, wi_x;
    logic signed [SW-1:0] sum_r, sum_i, rnd_r, rnd_i;
    logic signed [AW-1:0] xar_x, xai_x, pr_x, pi_x;
    logic [3:0]           sat_v;

    // Optional halving, then clamp; returns {saturated, value}.
    function automatic logic [DW:0] scale_sat(input logic signed [AW-1:0] s, input logic sc);
        logic signed [AW-1:0] t;
        t = s;
        if (sc) begin
            t = s + One;
            t = t >>> 1;
        end
        if (t > MaxV) begin
            scale_sat = {1'b1, MaxV[DW-1:0]};
        end else if (t < MinV) begin
            scale_sat = {1'b1, MinV[DW-1:0]};
        end else begin
            scale_sat = {1'b0, t[DW-1:0]};
        end
    endfunction

    always_comb begin
        xbr_x  = $signed({{TW{xb_r_i[DW-1]}}, xb_r_i});
        xbi_x  = $signed({{TW{xb_i_i[DW-1]}}, xb_i_i});
        wr_x   = $signed({{DW{w_r_i[TW-1]}}, w_r_i});
        wi_x   = $signed({{DW{w_i_i[TW-1]}}, w_i_i});
        m_rr_d = xbr_x * wr_x;
        m_ii_d = xbi_x * wi_x;
        m_ri_d = xbr_x * wi_x;
        m_ir_d = xbi_x * wr_x;
    end

    always_comb begin
        sum_r = $signed({m_rr_q[PW-1], m_rr_q}) - $signed({m_ii_q[PW-1], m_ii_q});
        sum_i = $signed({m_ri_q[PW-1], m_ri_q}) + $signed({m_ir_q[PW-1], m_ir_q});
        rnd_r = sum_r + RndK;
        rnd_i = sum_i + RndK;
        // Slicing off the low TW-1 bits is the arithmetic shift.
        pr2_d = rnd_r[SW-1:TW-1];
        pi2_d = rnd_i[SW-1:TW-1];
    end

    always_comb begin
        xar_x = $signed({{3{xar2_q[DW-1]}}, xar2_q});
        xai_x = $signed({{3{xai2_q[DW-1]}}, xai2_q});
        pr_x  = $signed({pr2_q[RW-1], pr2_q});
        pi_x  = $signed({pi2_q[RW-1], pi2_q});
        {sat_v[0], ya_r_d} = scale_sat(xar_x + pr_x, sc2_q);
        {sat_v[1], ya_i_d} = scale_sat(xai_x + pi_x, sc2_q);
        {sat_v[2], yb_r_d} = scale_sat(xar_x - pr_x, sc2_q);
        {sat_v[3], yb_i_d} = scale_sat(xai_x - pi_x, sc2_q);
        sat_d = v2_q & (|sat_v);
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            v1_q   <= 1'b0;
            sc1_q  <= 1'b0;
            xar1_q <= '0;
            xai1_q <= '0;
            m_rr_q <= '0;
            m_ii_q <= '0;
            m_ri_q <= '0;
            m_ir_q <= '0;
        end else begin
            v1_q <= in_valid_i;
            if (in_valid_i) begin
                sc1_q  <= scale_en_i;
                xar1_q <= xa_r_i;
                xai1_q <= xa_i_i;
                m_rr_q <= m_rr_d;
                m_ii_q <= m_ii_d;
                m_ri_q <= m_ri_d;
                m_ir_q <= m_ir_d;
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            v2_q   <= 1'b0;
            sc2_q  <= 1'b0;
            xar2_q <= '0;
            xai2_q <= '0;
            pr2_q  <= '0;
            pi2_q  <= '0;
        end else begin
            v2_q <= v1_q;
            if (v1_q) begin
                sc2_q  <= sc1_q;
                xar2_q <= xar1_q;
                xai2_q <= xai1_q;
                pr2_q  <= pr2_d;
                pi2_q  <= pi2_d;
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            out_valid_q <= 1'b0;
            sat_q       <= 1'b0;
            ya_r_q      <= '0;
            ya_i_q      <= '0;
            yb_r_q      <= '0;
            yb_i_q      <= '0;
        end else begin
            out_valid_q <= v2_q;
            sat_q       <= sat_d;
            if (v2_q) begin
                ya_r_q <= ya_r_d;
                ya_i_q <= ya_i_d;
                yb_r_q <= yb_r_d;
                yb_i_q <= yb_i_d;
            end
        end
    end

    // A qualified saturation outranks a coincident clear.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            sticky_q <= 1'b0;
        end else if (out_valid_q && sat_q) begin
            sticky_q <= 1'b1;
        end else if (ovf_clr_i) begin
            sticky_q <= 1'b0;
        end
    end

    assign out_valid_o  = out_valid_q;
    assign sat_o        = sat_q;
    assign ya_r_o       = ya_r_q;
    assign ya_i_o       = ya_i_q;
    assign yb_r_o       = yb_r_q;
    assign yb_i_o       = yb_i_q;
    assign ovf_sticky_o = sticky_q;

endmodule

// File: tb/tb_bfu_pipe.sv
// Directed and streaming checks for bfu_pipe against hand values and an integer reference model.
module tb_bfu_pipe;

    logic               clk = 1'b0;
    logic               rst, in_valid, scale_en, ovf_clr;
    logic signed [15:0] xa_r, xa_i, xb_r, xb_i, w_r, w_i;
    logic               out_valid, sat, ovf_sticky;
    logic signed [15:0] ya_r, ya_i, yb_r, yb_i;

    int n_cmp = 0;
    int n_err = 0;

    typedef struct {
        bit     v;
        longint yar, yai, ybr, ybi;
        bit     s;
    } exp_t;

    exp_t expq[76];

    always #5 clk = ~clk;

    bfu_pipe #(.DW(16), .TW(16)) dut (
        .clk_i        (clk),
        .rst_i        (rst),
        .in_valid_i   (in_valid),
        .scale_en_i   (scale_en),
        .xa_r_i       (xa_r),
        .xa_i_i       (xa_i),
        .xb_r_i       (xb_r),
        .xb_i_i       (xb_i),
        .w_r_i        (w_r),
        .w_i_i        (w_i),
        .ovf_clr_i    (ovf_clr),
        .out_valid_o  (out_valid),
        .ya_r_o       (ya_r),
        .ya_i_o       (ya_i),
        .yb_r_o       (yb_r),
        .yb_i_o       (yb_i),
        .sat_o        (sat),
        .ovf_sticky_o (ovf_sticky)
    );

    task automatic check(input string tag, input longint obs, input longint exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d, want %0d", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_in(input int xar, xai, xbr, xbi, wr, wi, input bit sc);
        xa_r = 16'(xar); xa_i = 16'(xai);
        xb_r = 16'(xbr); xb_i = 16'(xbi);
        w_r  = 16'(wr);  w_i  = 16'(wi);
        scale_en = sc;
    endtask

    // One sample, then two bubbles; checks the result as it reaches the output.
    task automatic run_vec(input string tag, input int xar, xai, xbr, xbi, wr, wi, input bit sc,
                           input int eyar, eyai, eybr, eybi, input bit esat);
        set_in(xar, xai, xbr, xbi, wr, wi, sc);
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        tick();
        check({tag, ".early_valid"}, out_valid, 0);
        tick();
        check({tag, ".valid"}, out_valid, 1);
        check({tag, ".ya_r"}, ya_r, eyar);
        check({tag, ".ya_i"}, ya_i, eyai);
        check({tag, ".yb_r"}, yb_r, eybr);
        check({tag, ".yb_i"}, yb_i, eybi);
        check({tag, ".sat"}, sat, esat);
    endtask

    function automatic void sat_one(input longint s, input bit sc, output longint y, output bit f);
        longint t;
        t = sc ? ((s + 1) >>> 1) : s;
        f = 1'b0;
        y = t;
        if (t > 32767) begin y = 32767; f = 1'b1; end
        if (t < -32768) begin y = -32768; f = 1'b1; end
    endfunction

    function automatic exp_t model(input longint xar, xai, xbr, xbi, wr, wi, input bit sc);
        exp_t   e;
        longint pr, pi;
        bit     f0, f1, f2, f3;
        pr = (xbr * wr - xbi * wi + 16384) >>> 15;
        pi = (xbr * wi + xbi * wr + 16384) >>> 15;
        sat_one(xar + pr, sc, e.yar, f0);
        sat_one(xai + pi, sc, e.yai, f1);
        sat_one(xar - pr, sc, e.ybr, f2);
        sat_one(xai - pi, sc, e.ybi, f3);
        e.s = f0 | f1 | f2 | f3;
        e.v = 1'b1;
        return e;
    endfunction

    initial begin
        rst = 1'b1; in_valid = 1'b0; ovf_clr = 1'b0;
        set_in(0, 0, 0, 0, 0, 0, 1'b0);
        tick();
        tick();
        check("rst.valid", out_valid, 0);
        check("rst.ya_r", ya_r, 0);
        check("rst.yb_i", yb_i, 0);
        check("rst.sat", sat, 0);
        check("rst.sticky", ovf_sticky, 0);
        rst = 1'b0;

        run_vec("unity", 1000, 0, 200, 0, 32767, 0, 1'b0, 1200, 0, 800, 0, 1'b0);
        run_vec("unity_sc", 1000, 0, 200, 0, 32767, 0, 1'b1, 600, 0, 400, 0, 1'b0);
        run_vec("minus_j", 0, 0, 100, 50, 0, -32768, 1'b0, 50, -100, -50, 100, 1'b0);
        check("minus_j.sticky", ovf_sticky, 0);

        run_vec("satur", 32767, 0, 32767, 0, 32767, 0, 1'b0, 32767, 0, 1, 0, 1'b1);
        check("satur.sticky_same", ovf_sticky, 0);
        tick();
        check("satur.sticky_next", ovf_sticky, 1);
        check("satur.bubble_sat", sat, 0);
        run_vec("satur_sc", 32767, 0, 32767, 0, 32767, 0, 1'b1, 32767, 0, 1, 0, 1'b0);

        ovf_clr = 1'b1;
        tick();
        ovf_clr = 1'b0;
        check("clr_alone", ovf_sticky, 0);
        run_vec("clr_race", 32767, 0, 32767, 0, 32767, 0, 1'b0, 32767, 0, 1, 0, 1'b1);
        ovf_clr = 1'b1;
        tick();
        check("clr_race.set_wins", ovf_sticky, 1);
        tick();
        ovf_clr = 1'b0;
        check("clr_race.cleared", ovf_sticky, 0);

        // Three saturating samples in flight, then a one-cycle reset.
        set_in(32767, 0, 32767, 0, 32767, 0, 1'b0);
        in_valid = 1'b1;
        tick();
        tick();
        tick();
        check("midrst.pre_valid", out_valid, 1);
        in_valid = 1'b0;
        rst = 1'b1;
        tick();
        rst = 1'b0;
        for (int k = 0; k < 3; k++) begin
            check($sformatf("midrst%0d.valid", k), out_valid, 0);
            check($sformatf("midrst%0d.ya_r", k), ya_r, 0);
            check($sformatf("midrst%0d.yb_r", k), yb_r, 0);
            check($sformatf("midrst%0d.sat", k), sat, 0);
            check($sformatf("midrst%0d.sticky", k), ovf_sticky, 0);
            tick();
        end

        // Streaming: 64 samples, gap on every 7th cycle, alternating scale_en.
        begin
            int     ns;
            logic [31:0] r0, r1, r2;
            ns = 0;
            for (int c = 0; c < 76; c++) begin
                if (c < 74 && (c % 7) != 6) begin
                    r0 = $urandom; r1 = $urandom; r2 = $urandom;
                    set_in(int'($signed(r0[15:0])), int'($signed(r0[31:16])),
                           int'($signed(r1[15:0])), int'($signed(r1[31:16])),
                           int'($signed(r2[15:0])), int'($signed(r2[31:16])), ns[0]);
                    in_valid = 1'b1;
                    expq[c] = model(xa_r, xa_i, xb_r, xb_i, w_r, w_i, ns[0]);
                    ns++;
                end else begin
                    in_valid = 1'b0;
                    expq[c] = '{v: 1'b0, yar: 0, yai: 0, ybr: 0, ybi: 0, s: 1'b0};
                end
                tick();
                if (c >= 2) begin
                    check($sformatf("str%0d.valid", c - 2), out_valid, expq[c-2].v);
                    if (expq[c-2].v) begin
                        check($sformatf("str%0d.ya_r", c - 2), ya_r, expq[c-2].yar);
                        check($sformatf("str%0d.ya_i", c - 2), ya_i, expq[c-2].yai);
                        check($sformatf("str%0d.yb_r", c - 2), yb_r, expq[c-2].ybr);
                        check($sformatf("str%0d.yb_i", c - 2), yb_i, expq[c-2].ybi);
                        check($sformatf("str%0d.sat", c - 2), sat, expq[c-2].s);
                    end else begin
                        check($sformatf("str%0d.bubble_sat", c - 2), sat, 0);
                    end
                end
            end
            check("str.sample_count", ns, 64);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
